// File: rtl/screen_ctrl.sv
// screen_ctrl: arbitrates CPU pixel/clear/swap commands over a 32x32 draw buffer and a display buffer read by scan-out.
// Optional SCREEN_TEARFREE_EN holds draw-to-display copies until vsync; otherwise the copy lands one cycle after accept.
module screen_ctrl #(
  parameter int SCR_W = 32,
  parameter int SCR_H = 32,
  parameter int CW    = 5
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CW-1:0]    cmd_x,
  input  logic [CW-1:0]    cmd_y,
  input  logic             vsync,
  input  logic [CW-1:0]    rd_row,
  output logic [SCR_W-1:0] rd_data,
  output logic             busy,
  output logic             swap_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  localparam logic [1:0]    OP_SET   = 2'b00;
  localparam logic [1:0]    OP_CLR   = 2'b01;
  localparam logic [1:0]    OP_CLS   = 2'b10;
  localparam logic [CW-1:0] LAST_ROW = CW'(SCR_H - 1);

  state_t           state_q, state_d;
  logic [SCR_W-1:0] draw_q [SCR_H];
  logic [SCR_W-1:0] draw_d [SCR_H];
  logic [SCR_W-1:0] disp_q [SCR_H];
  logic [SCR_W-1:0] disp_d [SCR_H];
  logic [CW-1:0]    row_q, row_d;
  logic [SCR_W-1:0] rd_data_q, rd_data_d;
  logic             busy_q, busy_d;
  logic             swap_done_q, swap_done_d;
  logic             accept;
  logic             load;
  logic             px_in_range;

  assign cmd_ready   = (state_q == IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign px_in_range = (int'(cmd_x) < SCR_W) && (int'(cmd_y) < SCR_H);

`ifdef SCREEN_TEARFREE_EN
  assign load = (state_q == SWAP_WAIT) && vsync;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign load = (state_q == SWAP_WAIT);
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    draw_d      = draw_q;
    disp_d      = disp_q;
    swap_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_SET, OP_CLR: begin
              // Out-of-range coordinates are accepted but dropped.
              if (px_in_range) draw_d[cmd_y][cmd_x] = (cmd_op == OP_SET);
            end
            OP_CLS: begin
              state_d = CLEAR;
              row_d   = '0;
            end
            default: state_d = SWAP_WAIT;
          endcase
        end
      end
      CLEAR: begin
        draw_d[row_q] = '0;
        if (row_q == LAST_ROW) begin
          state_d = IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      SWAP_WAIT: begin
        if (load) begin
          disp_d      = draw_q;
          swap_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reads use the pre-load display contents; a same-cycle load shows up on the next read.
    rd_data_d = (int'(rd_row) < SCR_H) ? disp_q[rd_row] : '0;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      draw_q      <= '{default: '0};
      disp_q      <= '{default: '0};
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      draw_q      <= draw_d;
      disp_q      <= disp_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign swap_done = swap_done_q;

endmodule
